// File: rtl/load_store_unit.sv
// load_store_unit
//   Sequences one load or store at a time between the datapath and a
//   byte-lane data memory. A request is captured in IDLE. Then either the
//   write strobe is pulsed for one cycle, or the read strobe is held for
//   MEM_LAT cycles. The result is presented as a response. Bad sizes and
//   accesses that would run past the last memory row are answered with
//   rsp_err. No memory strobe is raised for them.
//
// Ports
//   clock, reset            single clock, synchronous active-high reset
//   req_valid/req_ready     request handshake; req_write, req_size,
//                           req_signed, req_addr, req_wdata are its payload
//   rsp_valid/rsp_ready     response handshake; rsp_rdata, rsp_err payload
//   mem_addr, mem_data      byte address and right-justified store data
//   mem_DataType            captured access size (01 byte, 10 half, 11 word)
//   mem_EscMen, mem_ReadMen write / read strobes (never both high)
//   mem_saida               read data from memory, already zero-extended
//   dbg_state               current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The sender holds valid and its payload until that edge. Here,
// req_ready is high only in IDLE outside reset. Once rsp_valid rises, the
// response payload does not change until the edge where rsp_ready is seen.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_LAT    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH+1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [1:0]            mem_DataType,
  output logic                  mem_EscMen,
  output logic                  mem_ReadMen,
  input  logic [DATA_WIDTH-1:0] mem_saida,
  output logic [1:0]            dbg_state
);

  localparam int AW = ADDR_WIDTH + 2;
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic                  accept;
  logic                  top_row;
  logic                  req_bad;
  logic [DATA_WIDTH-1:0] load_ext;

  assign req_ready = (state_q == S_IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // Only the last row can wrap: a half at offset 3 or any unaligned word
  // would spill past the top of memory. Byte accesses never wrap.
  assign top_row = &req_addr[AW-1:2];
  assign req_bad = (req_size == 2'b00) ||
                   (top_row && (((req_size == 2'b10) && (req_addr[1:0] == 2'b11)) ||
                                ((req_size == 2'b11) && (req_addr[1:0] != 2'b00))));

  // Memory returns right-justified data zero-extended; only the sign fill is added here.
  always_comb begin
    load_ext = mem_saida;
    case (size_q)
      2'b01:   load_ext = {(signed_q ? {24{mem_saida[7]}}  : 24'h0), mem_saida[7:0]};
      2'b10:   load_ext = {(signed_q ? {16{mem_saida[15]}} : 16'h0), mem_saida[15:0]};
      default: load_ext = mem_saida;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    size_d      = size_q;
    signed_d    = signed_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d      = req_addr;
          data_d      = req_wdata;
          size_d      = req_size;
          signed_d    = req_signed;
          rsp_rdata_d = '0;
          rsp_err_d   = req_bad;
          cnt_d       = CW'(MEM_LAT - 1);
          if (req_bad)        state_d = S_RESP;
          else if (req_write) state_d = S_WRITE;
          else                state_d = S_READ;
        end
      end
      S_WRITE: state_d = S_RESP;
      S_READ: begin
        // The last read cycle is the one where the counter has reached zero.
        if (cnt_q == '0) begin
          rsp_rdata_d = load_ext;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Strobes are decoded from state, so leaving WRITE/READ drops them at once.
  assign rsp_valid    = (state_q == S_RESP);
  assign rsp_err      = rsp_err_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign mem_EscMen   = (state_q == S_WRITE);
  assign mem_ReadMen  = (state_q == S_READ);
  assign mem_addr     = addr_q;
  assign mem_data     = data_q;
  assign mem_DataType = size_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a MEM_LAT=1 instance with a byte-addressed
// memory model, plus a MEM_LAT=3 instance for the latency scenario.
module tb_load_store_unit;
  localparam int AW = 6;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, req_valid, req_write, req_signed, rsp_ready;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          req_ready, rsp_valid, rsp_err, mem_EscMen, mem_ReadMen;
  logic [31:0]   rsp_rdata, mem_data, mem_saida;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_DataType, dbg_state;

  logic          req_valid3, req_write3, req_signed3, rsp_ready3;
  logic [1:0]    req_size3;
  logic [AW-1:0] req_addr3;
  logic [31:0]   req_wdata3;
  logic          req_ready3, rsp_valid3, rsp_err3, mem_EscMen3, mem_ReadMen3;
  logic [31:0]   rsp_rdata3, mem_data3, mem_saida3;
  logic [AW-1:0] mem_addr3;
  logic [1:0]    mem_DataType3, dbg_state3;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .MEM_LAT(1)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_DataType(mem_DataType),
    .mem_EscMen(mem_EscMen), .mem_ReadMen(mem_ReadMen), .mem_saida(mem_saida),
    .dbg_state(dbg_state));

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .MEM_LAT(3)) dut3 (
    .clock(clock), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_write(req_write3), .req_size(req_size3), .req_signed(req_signed3),
    .req_addr(req_addr3), .req_wdata(req_wdata3), .rsp_valid(rsp_valid3),
    .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
    .mem_addr(mem_addr3), .mem_data(mem_data3), .mem_DataType(mem_DataType3),
    .mem_EscMen(mem_EscMen3), .mem_ReadMen(mem_ReadMen3), .mem_saida(mem_saida3),
    .dbg_state(dbg_state3));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [7:0] ref_bytes [64];

  function automatic int nb(input logic [1:0] sz);
    case (sz)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic exp_err(input logic [1:0] sz, input logic [5:0] ad);
    return (sz == 2'b00) || (int'(ad) + nb(sz) > 64);
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic sg, input logic [5:0] ad);
    longint v = 0;
    int n = nb(sz);
    for (int i = 0; i < n; i++) v += longint'(ref_bytes[(int'(ad) + i) % 64]) << (8 * i);
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [5:0] ad, input logic [31:0] wd);
    for (int i = 0; i < nb(sz); i++) ref_bytes[(int'(ad) + i) % 64] = wd[8 * i +: 8];
  endtask

  // ---------------- memory models ----------------
  logic [7:0]  mem_bytes [64];
  logic        mem_init = 1'b0;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_val = 32'h0;

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem_bytes[i] <= ref_bytes[i];
    end else if (mem_EscMen) begin
      for (int i = 0; i < 4; i++)
        if (i < nb(mem_DataType)) mem_bytes[(int'(mem_addr) + i) % 64] <= mem_data[8 * i +: 8];
    end
  end

  always_comb begin
    mem_saida = 32'h0;
    if (ovr_en) mem_saida = ovr_val;
    else
      for (int i = 0; i < 4; i++)
        if (i < nb(mem_DataType)) mem_saida[8 * i +: 8] = mem_bytes[(int'(mem_addr) + i) % 64];
  end

  // Three-cycle memory: data is valid only in the third consecutive read cycle.
  int rd_run3 = 0;
  always @(posedge clock) rd_run3 <= mem_ReadMen3 ? rd_run3 + 1 : 0;
  always_comb begin
    mem_saida3 = 32'hBAD0_0BAD;
    if (mem_ReadMen3 && rd_run3 == 2)
      mem_saida3 = (mem_DataType3 == 2'b10) ? 32'h0000_5678 : 32'h1234_5678;
  end

  // ---------------- driver ----------------
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          esc;
    int          rd;
    int          both;
    int          rdy_hi;
    int          acc;
    logic [5:0]  maddr;
    logic [31:0] mdata;
    logic [1:0]  mtype;
  } obs_t;

  // Called at a negedge with rsp_ready high; returns at the negedge of the
  // cycle after the response handshake.
  task automatic drive_txn(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [5:0] ad, input logic [31:0] wd, output obs_t o);
    int waitc = 0;
    o = '{data: 32'h0, err: 1'b0, lat: -1, esc: 0, rd: 0, both: 0, rdy_hi: 0,
          acc: 0, maddr: 6'h0, mdata: 32'h0, mtype: 2'b00};
    req_write = w; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
    req_valid = 1'b1;
    while (!req_ready && waitc < 20) begin @(negedge clock); waitc++; end
    if (!req_ready) begin req_valid = 1'b0; return; end
    o.acc = cyc;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 1) begin o.maddr = mem_addr; o.mdata = mem_data; o.mtype = mem_DataType; end
      if (mem_EscMen) o.esc++;
      if (mem_ReadMen) o.rd++;
      if (mem_EscMen && mem_ReadMen) o.both++;
      if (req_ready) o.rdy_hi++;
      if (rsp_valid) begin o.lat = k; o.data = rsp_rdata; o.err = rsp_err; break; end
      @(negedge clock);
    end
    @(negedge clock);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 64; i++) ref_bytes[i] = 8'($urandom);
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    req_valid3 = 1'b0; req_write3 = 1'b0; req_size3 = 2'b00; req_signed3 = 1'b0;
    req_addr3 = '0; req_wdata3 = '0; rsp_ready3 = 1'b1;
    mem_init = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h exp 0", rsp_rdata); end
    checks++; if (mem_addr !== 6'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    checks++; if (mem_data !== 32'h0) begin errors++; $display("FAIL reset_mem_data got %h exp 0", mem_data); end
    checks++; if (mem_DataType !== 2'b00) begin errors++; $display("FAIL reset_mem_type got %b exp 0", mem_DataType); end
    checks++; if ({mem_EscMen, mem_ReadMen} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b exp 00", {mem_EscMen, mem_ReadMen}); end
    checks++; if (rsp_valid3 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid3 got %b exp 0", rsp_valid3); end
    mem_init = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", req_ready); end
    @(negedge clock);
  endtask

  task automatic test_store_load_word();
    obs_t o;
    drive_txn(1'b1, 2'b11, 1'b0, 6'h04, 32'hDEAD_BEEF, o);
    ref_store(2'b11, 6'h04, 32'hDEAD_BEEF);
    checks++; if (o.lat !== 2) begin errors++; $display("FAIL sw_latency got %0d exp 2", o.lat); end
    checks++; if (o.esc !== 1) begin errors++; $display("FAIL sw_esc_cycles got %0d exp 1", o.esc); end
    checks++; if (o.rd !== 0) begin errors++; $display("FAIL sw_read_cycles got %0d exp 0", o.rd); end
    checks++; if ({o.err, o.data} !== 33'h0) begin errors++; $display("FAIL sw_rsp got err %b data %h exp 0 0", o.err, o.data); end
    checks++; if ({o.maddr, o.mdata, o.mtype} !== {6'h04, 32'hDEAD_BEEF, 2'b11}) begin
      errors++; $display("FAIL sw_mem_bus got %h %h %b exp 04 deadbeef 11", o.maddr, o.mdata, o.mtype); end
    checks++; if (o.rdy_hi !== 0) begin errors++; $display("FAIL sw_ready_busy got %0d exp 0", o.rdy_hi); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL sw_ready_after got %b exp 1", req_ready); end
    drive_txn(1'b0, 2'b11, 1'b0, 6'h04, 32'h0, o);
    checks++; if (o.data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", o.data); end
    checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL lw_err got %b exp 0", o.err); end
    checks++; if (o.lat !== 2) begin errors++; $display("FAIL lw_latency got %0d exp 2", o.lat); end
    checks++; if ({o.rd, o.esc} !== {32'd1, 32'd0}) begin errors++; $display("FAIL lw_strobes got rd %0d esc %0d exp 1 0", o.rd, o.esc); end
  endtask

  task automatic test_sign_ext();
    obs_t o;
    ovr_en = 1'b1;
    ovr_val = 32'h0000_0080;
    drive_txn(1'b0, 2'b01, 1'b1, 6'h05, 32'h0, o);
    checks++; if (o.data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_signed got %h exp ffffff80", o.data); end
    drive_txn(1'b0, 2'b01, 1'b0, 6'h05, 32'h0, o);
    checks++; if (o.data !== 32'h0000_0080) begin errors++; $display("FAIL lb_unsigned got %h exp 00000080", o.data); end
    ovr_val = 32'h0000_8001;
    drive_txn(1'b0, 2'b10, 1'b1, 6'h06, 32'h0, o);
    checks++; if (o.data !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_signed got %h exp ffff8001", o.data); end
    drive_txn(1'b0, 2'b10, 1'b0, 6'h06, 32'h0, o);
    checks++; if (o.data !== 32'h0000_8001) begin errors++; $display("FAIL lh_unsigned got %h exp 00008001", o.data); end
    ovr_val = 32'hCAFE_F00D;
    drive_txn(1'b0, 2'b11, 1'b1, 6'h08, 32'h0, o);
    checks++; if (o.data !== 32'hCAFE_F00D) begin errors++; $display("FAIL lw_signed_unchanged got %h exp cafef00d", o.data); end
    ovr_en = 1'b0;
  endtask

  task automatic test_errors();
    obs_t o;
    logic        ws  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0]  szs [8] = '{2'b00, 2'b11, 2'b10, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10};
    logic [5:0]  ads [8] = '{6'h00, 6'h3D, 6'h3F, 6'h3E, 6'h3F, 6'h3C, 6'h10, 6'h3D};
    logic        ers [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      logic [31:0] wd = $urandom;
      logic [31:0] ed = (ers[i] || ws[i]) ? 32'h0 : exp_load(szs[i], 1'b0, ads[i]);
      drive_txn(ws[i], szs[i], 1'b0, ads[i], wd, o);
      if (!ers[i] && ws[i]) ref_store(szs[i], ads[i], wd);
      checks++; if (o.err !== ers[i]) begin errors++; $display("FAIL err_flag[%0d] got %b exp %b", i, o.err, ers[i]); end
      checks++; if (o.lat !== (ers[i] ? 1 : 2)) begin errors++; $display("FAIL err_latency[%0d] got %0d exp %0d", i, o.lat, ers[i] ? 1 : 2); end
      checks++; if (o.esc + o.rd !== (ers[i] ? 0 : 1)) begin errors++; $display("FAIL err_strobes[%0d] got %0d exp %0d", i, o.esc + o.rd, ers[i] ? 0 : 1); end
      checks++; if (o.data !== ed) begin errors++; $display("FAIL err_rdata[%0d] got %h exp %h", i, o.data, ed); end
    end
  endtask

  task automatic test_random();
    obs_t o;
    for (int i = 0; i < 60; i++) begin
      logic        w  = 1'($urandom_range(0, 1));
      logic [1:0]  sz = 2'($urandom_range(0, 3));
      logic        sg = 1'($urandom_range(0, 1));
      logic [5:0]  ad = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(60, 63)) : 6'($urandom_range(0, 63));
      logic [31:0] wd = $urandom;
      logic        ee = exp_err(sz, ad);
      logic [31:0] ed = (ee || w) ? 32'h0 : exp_load(sz, sg, ad);
      int          el = ee ? 1 : 2;
      drive_txn(w, sz, sg, ad, wd, o);
      if (!ee && w) ref_store(sz, ad, wd);
      checks++; if (o.err !== ee) begin errors++; $display("FAIL rnd_err[%0d] got %b exp %b", i, o.err, ee); end
      checks++; if (o.data !== ed) begin errors++; $display("FAIL rnd_data[%0d] got %h exp %h", i, o.data, ed); end
      checks++; if (o.lat !== el) begin errors++; $display("FAIL rnd_latency[%0d] got %0d exp %0d", i, o.lat, el); end
      checks++; if (o.esc !== ((!ee && w) ? 1 : 0)) begin errors++; $display("FAIL rnd_esc[%0d] got %0d", i, o.esc); end
      checks++; if (o.rd !== ((!ee && !w) ? 1 : 0)) begin errors++; $display("FAIL rnd_read[%0d] got %0d", i, o.rd); end
      checks++; if (o.both !== 0) begin errors++; $display("FAIL rnd_overlap[%0d] got %0d exp 0", i, o.both); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    int kinds [9] = '{0, 0, 2, 2, 1, 1, 0, 2, 1};  // 0 store, 1 load, 2 error
    int acc [9];
    for (int i = 0; i < 9; i++) begin
      logic [5:0]  ad = {4'($urandom_range(0, 14)), 2'b00};
      logic [31:0] wd = $urandom;
      logic [1:0]  sz = (kinds[i] == 2) ? 2'b00 : 2'b11;
      logic [31:0] ed = exp_load(2'b11, 1'b0, ad);
      drive_txn(kinds[i] == 0, sz, 1'b0, ad, wd, o);
      acc[i] = o.acc;
      if (kinds[i] == 0) ref_store(2'b11, ad, wd);
      if (kinds[i] == 1) begin
        checks++; if (o.data !== ed) begin errors++; $display("FAIL b2b_load[%0d] got %h exp %h", i, o.data, ed); end
      end
    end
    for (int i = 0; i < 8; i++) begin
      int ei = (kinds[i] == 2) ? 2 : 3;
      checks++; if (acc[i + 1] - acc[i] !== ei) begin
        errors++; $display("FAIL b2b_interval[%0d] got %0d exp %0d", i, acc[i + 1] - acc[i], ei); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ed = exp_load(2'b11, 1'b0, 6'h04);
    logic [31:0] wd = $urandom;
    int waitc = 0;
    rsp_ready = 1'b0;
    req_write = 1'b0; req_size = 2'b11; req_signed = 1'b0; req_addr = 6'h04; req_valid = 1'b1;
    while (!req_ready && waitc < 20) begin @(negedge clock); waitc++; end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    waitc = 0;
    while (!rsp_valid && waitc < 20) begin @(negedge clock); waitc++; end
    // Offer a store while the load response is stalled; it must wait.
    req_write = 1'b1; req_size = 2'b11; req_addr = 6'h08; req_wdata = wd; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, ed}) begin
        errors++; $display("FAIL bp_hold[%0d] got v%b e%b %h exp v1 e0 %h", k, rsp_valid, rsp_err, rsp_rdata, ed); end
      checks++; if ({req_ready, mem_EscMen} !== 2'b00) begin
        errors++; $display("FAIL bp_ignore[%0d] got ready %b esc %b exp 0 0", k, req_ready, mem_EscMen); end
      @(negedge clock);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    checks++; if ({req_ready, rsp_valid} !== 2'b10) begin
      errors++; $display("FAIL bp_release got ready %b valid %b exp 1 0", req_ready, rsp_valid); end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    ref_store(2'b11, 6'h08, wd);
    checks++; if ({mem_EscMen, mem_addr, mem_data} !== {1'b1, 6'h08, wd}) begin
      errors++; $display("FAIL bp_next_store got esc %b addr %h data %h exp 1 08 %h", mem_EscMen, mem_addr, mem_data, wd); end
    @(negedge clock);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_next_rsp got %b exp 1", rsp_valid); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_read();
    int seen = 0;
    int waitc = 0;
    req_write = 1'b0; req_size = 2'b11; req_signed = 1'b0; req_addr = 6'h04; req_valid = 1'b1;
    while (!req_ready && waitc < 20) begin @(negedge clock); waitc++; end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    checks++; if (mem_ReadMen !== 1'b1) begin errors++; $display("FAIL rst_read_active got %b exp 1", mem_ReadMen); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if ({mem_ReadMen, rsp_valid, req_ready} !== 3'b000) begin
      errors++; $display("FAIL rst_read_drop got rd %b valid %b ready %b exp 000", mem_ReadMen, rsp_valid, req_ready); end
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_read_ready got %b exp 1", req_ready); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (rsp_valid || mem_ReadMen) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_read_no_rsp got %0d active cycles exp 0", seen); end
  endtask

  task automatic test_mem_lat3();
    logic [1:0]  szs [2] = '{2'b11, 2'b10};
    logic [31:0] eds [2] = '{32'h1234_5678, 32'h0000_5678};
    for (int t = 0; t < 2; t++) begin
      int waitc = 0;
      int rd = 0;
      int first = -1;
      int last = -1;
      int lat = -1;
      logic [31:0] got = 32'h0;
      req_write3 = 1'b0; req_size3 = szs[t]; req_signed3 = 1'b0; req_addr3 = 6'h10; req_valid3 = 1'b1;
      while (!req_ready3 && waitc < 20) begin @(negedge clock); waitc++; end
      @(posedge clock);
      @(negedge clock);
      req_valid3 = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        if (mem_ReadMen3) begin rd++; if (first < 0) first = k; last = k; end
        if (rsp_valid3) begin lat = k; got = rsp_rdata3; break; end
        @(negedge clock);
      end
      @(negedge clock);
      checks++; if (rd !== 3) begin errors++; $display("FAIL lat3_read_cycles[%0d] got %0d exp 3", t, rd); end
      checks++; if ({first, last} !== {32'd1, 32'd3}) begin errors++; $display("FAIL lat3_read_window[%0d] got %0d..%0d exp 1..3", t, first, last); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL lat3_latency[%0d] got %0d exp 4", t, lat); end
      checks++; if (got !== eds[t]) begin errors++; $display("FAIL lat3_data[%0d] got %h exp %h", t, got, eds[t]); end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_store_load_word();
    test_sign_ext();
    test_errors();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_read();
    test_mem_lat3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store sequencer between the processor datapath and the byte-lane data memory. It accepts one load or store request at a time over a valid/ready handshake and drives the memory's write strobe, read enable, access size and address for exactly the required cycles. Loads are returned sign- or zero-extended. Illegal sizes and accesses that would wrap past the top memory row are rejected with an error response before any memory strobe is raised.

## Interface
- DATA_WIDTH, 32, data bus width (fixed 32; byte lanes assumed)
- ADDR_WIDTH, 4, memory row-address width; byte address is ADDR_WIDTH+2 bits
- MEM_LAT, 1, memory read latency in cycles (≥1)

- clock  in  1  single clock; memory write_clock/read_clock tied to it externally
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept (high only in IDLE, low while reset asserted)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  01 byte, 10 half, 11 word; 00 illegal
- req_signed  in  1  loads: sign-extend (ignored for stores and words)
- req_addr  in  ADDR_WIDTH+2  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  request rejected
- mem_addr  out  ADDR_WIDTH+2  to memory addr
- mem_data  out  32  to memory data (unrotated; memory rotates lanes)
- mem_DataType  out  2  copy of captured req_size
- mem_EscMen  out  1  memory write enable
- mem_ReadMen  out  1  memory read enable
- mem_saida  in  32  memory read data, zero-extended by memory

## Operation
- States: IDLE, WRITE, READ, RESP.
- Reset: state IDLE; rsp_valid, rsp_err, mem_EscMen, mem_ReadMen = 0; rsp_rdata, mem_addr, mem_data, mem_DataType = 0; latency counter = 0.
- IDLE: on req_valid & req_ready, capture all req_* fields into registers.
  - Error if size = 00, or if addr[ADDR_WIDTH+1:2] is all-ones and (half with offset 3, or word with offset ≠ 0). Error → RESP with rsp_err=1, rsp_rdata=0; no strobe.
  - Else store → WRITE; load → READ with counter = MEM_LAT-1.
- WRITE: mem_EscMen=1 for exactly this cycle; → RESP, rsp_rdata=0.
- READ: mem_ReadMen=1 every READ cycle; counter decrements; when counter = 0, sample mem_saida at the clock edge and → RESP.
  - Byte: bits[31:8] = signed ? {24{d[7]}} : 0. Half: bits[31:16] = signed ? {16{d[15]}} : 0. Word: unchanged.
- RESP: rsp_valid=1; all rsp_* outputs held stable until rsp_ready; on rsp_ready → IDLE, rsp_valid=0 on the next cycle.
- mem_addr, mem_data and mem_DataType are held constant from the cycle after accept until return to IDLE. They are not cleared in IDLE; only the strobes are cleared.
- Reset mid-operation: next cycle is IDLE with the reset values above, including an immediate drop of any strobe. The pending response is discarded.

## Timing
- Accept at edge T (end of cycle where valid & ready).
- Store: mem_EscMen high in cycle T+1 only; rsp_valid from T+2.
- Load: mem_ReadMen high cycles T+1 … T+MEM_LAT; data sampled at end of T+MEM_LAT; rsp_valid from T+MEM_LAT+1.
- Error: rsp_valid from T+1; no strobes at any time.
- Throughput with rsp_ready tied high:
  - Load: one per MEM_LAT+2 cycles.
  - Store: one per 3 cycles.
  - Error: one per 2 cycles.
- req_ready is 0 from T+1 until the cycle after the response handshake.
- mem_EscMen and mem_ReadMen are never high in the same cycle.

## Test plan
- Store/load word: store 0xDEADBEEF @0x04 size 11 → EscMen one cycle at T+1. Then load 0x04 size 11 → rsp_rdata 0xDEADBEEF at T+2 (MEM_LAT=1), rsp_err 0.
- Byte sign extension: memory returns 0x00000080 for byte load @0x05. Signed → 0xFFFFFF80; unsigned → 0x00000080. Half returning 0x00008001, signed → 0xFFFF8001.
- Errors: size 00 @0x00 → rsp_err 1 at T+1, no strobe. Word @0x3D → rsp_err 1. Half @0x3F → rsp_err 1. Half @0x3E → accepted.
- Backpressure: hold rsp_ready=0 for 5 cycles after a load → rsp_valid/rsp_rdata stable throughout, req_ready 0. A new req_valid is ignored until the cycle after the handshake.
- MEM_LAT=3: load → mem_ReadMen high exactly 3 cycles (T+1..T+3), rsp_valid at T+4.
- Reset during READ: assert reset at T+1 → next cycle mem_ReadMen 0, rsp_valid 0, req_ready 1 after reset deasserts, and no response is ever produced.
